// File: rtl/int_issue_queue.sv
// ---------------------------------------------------------------------------
// int_issue_queue
// Integer issue queue sitting between dispatch and the integer execution pipe.
// Holds renamed uops until both physical sources are ready (snooping writeback
// wakeups), issues the oldest ready uop each cycle by ROB age, and selectively
// kills entries younger than a redirecting ROB index.
//
// Optional feature macro: IQ_DUAL_WAKEUP_EN
//   defined   -> second wakeup port (wb1_valid / wb1_prd) exists and feeds both
//                resident wakeup and the enqueue bypass.
//   undefined -> only wb0 wakes entries.
// ---------------------------------------------------------------------------
module int_issue_queue #(
   parameter int DEPTH     = 8,
   parameter int PAYLOAD_W = 128,
   parameter int PREG_W    = 6,
   parameter int ROB_W     = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   // dispatch side
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [PREG_W-1:0]          enq_prs1,
   input  logic [PREG_W-1:0]          enq_prs2,
   input  logic [PREG_W-1:0]          enq_prd,
   input  logic                       enq_src1_is_reg,
   input  logic                       enq_src2_is_reg,
   input  logic                       enq_src1_ready,
   input  logic                       enq_src2_ready,
   input  logic                       enq_robidx_flag,
   input  logic [ROB_W-1:0]           enq_robidx,
   input  logic [PAYLOAD_W-1:0]       enq_payload,
   // wakeup broadcasts
   input  logic                       wb0_valid,
   input  logic [PREG_W-1:0]          wb0_prd,
`ifdef IQ_DUAL_WAKEUP_EN
   input  logic                       wb1_valid,
   input  logic [PREG_W-1:0]          wb1_prd,
`endif
   // issue side
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [PREG_W-1:0]          issue_prs1,
   output logic [PREG_W-1:0]          issue_prs2,
   output logic [PREG_W-1:0]          issue_prd,
   output logic                       issue_robidx_flag,
   output logic [ROB_W-1:0]           issue_robidx,
   output logic                       issue_src1_is_reg,
   output logic                       issue_src2_is_reg,
   output logic [PAYLOAD_W-1:0]       issue_payload,
   // redirect
   input  logic                       flush_valid,
   input  logic                       flush_robidx_flag,
   input  logic [ROB_W-1:0]           flush_robidx,
   output logic [$clog2(DEPTH):0]     iq_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   // ROB age: A is older than B. Opposite flags mean B's index has wrapped.
   function automatic logic is_older(input logic fa, input logic [ROB_W-1:0] ia,
                                     input logic fb, input logic [ROB_W-1:0] ib);
      return (fa == fb) ? (ia < ib) : (ia > ib);
   endfunction

   // entry state
   logic [DEPTH-1:0]     r_valid;
   logic [DEPTH-1:0]     r_rdy1;
   logic [DEPTH-1:0]     r_rdy2;
   logic [DEPTH-1:0]     r_s1reg;
   logic [DEPTH-1:0]     r_s2reg;
   logic [DEPTH-1:0]     r_flag;
   logic [PREG_W-1:0]    r_prs1    [DEPTH];
   logic [PREG_W-1:0]    r_prs2    [DEPTH];
   logic [PREG_W-1:0]    r_prd     [DEPTH];
   logic [ROB_W-1:0]     r_idx     [DEPTH];
   logic [PAYLOAD_W-1:0] r_payload [DEPTH];
   logic [CNT_W-1:0]     r_count;

   // combinational
   logic [DEPTH-1:0]     w_wake1;
   logic [DEPTH-1:0]     w_wake2;
   logic                 w_enq_hit1;
   logic                 w_enq_hit2;
   logic                 w_enq_rdy1;
   logic                 w_enq_rdy2;
   logic [DEPTH-1:0]     w_selectable;
   logic [DEPTH-1:0]     w_kill;
   logic                 w_any_sel;
   logic [IDX_W-1:0]     w_sel;
   logic [IDX_W-1:0]     w_free;
   logic                 w_enq_fire;
   logic                 w_issue_fire;
   logic [DEPTH-1:0]     w_valid_nxt;
   logic [CNT_W-1:0]     w_count_nxt;

   // Wakeup tag match for resident entries and the same-cycle enqueue bypass.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_enq_hit1 = wb0_valid && (wb0_prd == enq_prs1);
      w_enq_hit2 = wb0_valid && (wb0_prd == enq_prs2);
`ifdef IQ_DUAL_WAKEUP_EN
      w_enq_hit1 = w_enq_hit1 | (wb1_valid && (wb1_prd == enq_prs1));
      w_enq_hit2 = w_enq_hit2 | (wb1_valid && (wb1_prd == enq_prs2));
`endif
      for (int i = 0; i < DEPTH; i++) begin
         w_wake1[i] = wb0_valid && (wb0_prd == r_prs1[i]);
         w_wake2[i] = wb0_valid && (wb0_prd == r_prs2[i]);
`ifdef IQ_DUAL_WAKEUP_EN
         w_wake1[i] = w_wake1[i] | (wb1_valid && (wb1_prd == r_prs1[i]));
         w_wake2[i] = w_wake2[i] | (wb1_valid && (wb1_prd == r_prs2[i]));
`endif
      end
      w_enq_rdy1 = ~enq_src1_is_reg | (enq_prs1 == '0) | enq_src1_ready | w_enq_hit1;
      w_enq_rdy2 = ~enq_src2_is_reg | (enq_prs2 == '0) | enq_src2_ready | w_enq_hit2;
   end

   // Oldest-ready select, lowest-index free slot, and flush kill mask.
   always_comb begin
      w_any_sel    = 1'b0;
      w_sel        = '0;
      w_free       = '0;
      w_selectable = r_valid & r_rdy1 & r_rdy2;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_selectable[i] &&
             (!w_any_sel || is_older(r_flag[i], r_idx[i], r_flag[w_sel], r_idx[w_sel]))) begin
            w_any_sel = 1'b1;
            w_sel     = IDX_W'(i);
         end
         w_kill[i] = r_valid[i] &&
                     is_older(flush_robidx_flag, flush_robidx, r_flag[i], r_idx[i]);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) w_free = IDX_W'(i);
      end
   end

   assign enq_ready    = (r_count < CNT_W'(DEPTH));
   assign issue_valid  = w_any_sel & ~flush_valid;
   assign w_enq_fire   = enq_valid & enq_ready & ~flush_valid;
   assign w_issue_fire = issue_valid & issue_ready;
   assign iq_count     = r_count;

   assign issue_prs1        = r_prs1[w_sel];
   assign issue_prs2        = r_prs2[w_sel];
   assign issue_prd         = r_prd[w_sel];
   assign issue_robidx_flag = r_flag[w_sel];
   assign issue_robidx      = r_idx[w_sel];
   assign issue_src1_is_reg = r_s1reg[w_sel];
   assign issue_src2_is_reg = r_s2reg[w_sel];
   assign issue_payload     = r_payload[w_sel];

   // Next valid vector and occupancy; enqueue, issue and flush resolve together.
   always_comb begin
      w_valid_nxt = r_valid;
      if (flush_valid) begin
         w_valid_nxt = r_valid & ~w_kill;
      end else begin
         if (w_issue_fire) w_valid_nxt[w_sel]  = 1'b0;
         if (w_enq_fire)   w_valid_nxt[w_free] = 1'b1;
      end
      w_count_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_count_nxt = w_count_nxt + CNT_W'(w_valid_nxt[i]);
      end
   end

   // Valid bits and count: the only state that needs reset.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_valid <= '0;
         r_count <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         r_count <= w_count_nxt;
      end
   end

   // Entry fields and readiness flags: written on enqueue, flags set by wakeup.
   always_ff @(posedge clock) begin
      // NOTE: entry storage is not reset; it is only observed through a valid bit that is.
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && w_wake1[i]) r_rdy1[i] <= 1'b1;
         if (r_valid[i] && w_wake2[i]) r_rdy2[i] <= 1'b1;
         if (w_enq_fire && (w_free == IDX_W'(i))) begin
            r_rdy1[i]    <= w_enq_rdy1;
            r_rdy2[i]    <= w_enq_rdy2;
            r_s1reg[i]   <= enq_src1_is_reg;
            r_s2reg[i]   <= enq_src2_is_reg;
            r_flag[i]    <= enq_robidx_flag;
            r_prs1[i]    <= enq_prs1;
            r_prs2[i]    <= enq_prs2;
            r_prd[i]     <= enq_prd;
            r_idx[i]     <= enq_robidx;
            r_payload[i] <= enq_payload;
         end
      end
   end

endmodule

// File: tb/tb_int_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_int_issue_queue
// Directed self-checking bench. Expected issues are pushed to a scoreboard as
// stimulus is driven and popped whenever the DUT completes an issue handshake.
// ---------------------------------------------------------------------------
module tb_int_issue_queue;

   logic         clock = 1'b0;
   logic         reset;
   logic         enq_valid, enq_ready;
   logic [5:0]   enq_prs1, enq_prs2, enq_prd;
   logic         enq_src1_is_reg, enq_src2_is_reg, enq_src1_ready, enq_src2_ready;
   logic         enq_robidx_flag;
   logic [3:0]   enq_robidx;
   logic [127:0] enq_payload;
   logic         wb0_valid;
   logic [5:0]   wb0_prd;
`ifdef IQ_DUAL_WAKEUP_EN
   logic         wb1_valid;
   logic [5:0]   wb1_prd;
`endif
   logic         issue_valid, issue_ready;
   logic [5:0]   issue_prs1, issue_prs2, issue_prd;
   logic         issue_robidx_flag;
   logic [3:0]   issue_robidx;
   logic         issue_src1_is_reg, issue_src2_is_reg;
   logic [127:0] issue_payload;
   logic         flush_valid, flush_robidx_flag;
   logic [3:0]   flush_robidx;
   logic [3:0]   iq_count;

   int_issue_queue #(.DEPTH(8), .PAYLOAD_W(128), .PREG_W(6), .ROB_W(4)) dut (
      .clock(clock), .reset(reset),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_prs1(enq_prs1), .enq_prs2(enq_prs2), .enq_prd(enq_prd),
      .enq_src1_is_reg(enq_src1_is_reg), .enq_src2_is_reg(enq_src2_is_reg),
      .enq_src1_ready(enq_src1_ready), .enq_src2_ready(enq_src2_ready),
      .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
      .enq_payload(enq_payload),
      .wb0_valid(wb0_valid), .wb0_prd(wb0_prd),
`ifdef IQ_DUAL_WAKEUP_EN
      .wb1_valid(wb1_valid), .wb1_prd(wb1_prd),
`endif
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_prs1(issue_prs1), .issue_prs2(issue_prs2), .issue_prd(issue_prd),
      .issue_robidx_flag(issue_robidx_flag), .issue_robidx(issue_robidx),
      .issue_src1_is_reg(issue_src1_is_reg), .issue_src2_is_reg(issue_src2_is_reg),
      .issue_payload(issue_payload),
      .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag),
      .flush_robidx(flush_robidx), .iq_count(iq_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [5:0]   prs1, prs2, prd;
      logic         s1reg, s2reg;
      logic         flag;
      logic [3:0]   idx;
      logic [127:0] pl;
   } exp_t;

   exp_t table_q [32];
   exp_t sb [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      enq_valid   = 1'b0;
      wb0_valid   = 1'b0;
      flush_valid = 1'b0;
`ifdef IQ_DUAL_WAKEUP_EN
      wb1_valid   = 1'b0;
`endif
   endtask

   // Drive one dispatch offer and remember what it should look like at issue.
   task automatic enq(input logic [5:0] p1, input logic s1reg, input logic s1rdy,
                      input logic [5:0] p2, input logic s2reg, input logic s2rdy,
                      input logic [5:0] prd, input logic flag, input logic [3:0] idx);
      exp_t e;
      e.prs1 = p1; e.prs2 = p2; e.prd = prd; e.s1reg = s1reg; e.s2reg = s2reg;
      e.flag = flag; e.idx = idx;
      e.pl   = {16{3'b101, flag, idx}} ^ {64'(p1), 64'(prd)};
      table_q[{flag, idx}] = e;
      enq_valid = 1'b1;
      enq_prs1 = p1; enq_src1_is_reg = s1reg; enq_src1_ready = s1rdy;
      enq_prs2 = p2; enq_src2_is_reg = s2reg; enq_src2_ready = s2rdy;
      enq_prd = prd; enq_robidx_flag = flag; enq_robidx = idx; enq_payload = e.pl;
   endtask

   task automatic expect_issue(input logic flag, input logic [3:0] idx);
      sb.push_back(table_q[{flag, idx}]);
   endtask

   // Sample the issue handshake for this cycle, advance one edge, go idle.
   task automatic cyc();
      exp_t e;
      #1;
      if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
         check("sb_has_expected", 1'(sb.size() != 0), 1'b1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("issue_robidx", {issue_robidx_flag, issue_robidx}, {e.flag, e.idx});
            check("issue_regs", {issue_prs1, issue_prs2, issue_prd, issue_src1_is_reg, issue_src2_is_reg},
                  {e.prs1, e.prs2, e.prd, e.s1reg, e.s2reg});
            check("issue_payload", issue_payload, e.pl);
         end
      end
      @(posedge clock);
      #1;
      idle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      issue_ready = 1'b1;
      enq_prs1 = '0; enq_prs2 = '0; enq_prd = '0;
      enq_src1_is_reg = 1'b0; enq_src2_is_reg = 1'b0;
      enq_src1_ready = 1'b0; enq_src2_ready = 1'b0;
      enq_robidx_flag = 1'b0; enq_robidx = '0; enq_payload = '0;
      wb0_prd = '0; flush_robidx_flag = 1'b0; flush_robidx = '0;
`ifdef IQ_DUAL_WAKEUP_EN
      wb1_prd = '0;
`endif
      // reset state
      reset = 1'b1;
      #3;
      check("rst_count", iq_count, 0);
      check("rst_issue_valid", issue_valid, 0);
      check("rst_enq_ready", enq_ready, 1);
      @(posedge clock); #1; reset = 1'b0; #1;

      // basic ready enqueue -> issue next cycle
      enq(5, 1, 1, 0, 1, 0, 20, 0, 3);
      expect_issue(0, 3);
      cyc();
      check("t1_count1", iq_count, 1);
      check("t1_issue_valid", issue_valid, 1);
      check("t1_robidx", issue_robidx, 3);
      cyc();
      check("t1_count0", iq_count, 0);
      check("t1_empty", issue_valid, 0);

      // younger ready bypasses older unready; wakeup releases the older
      enq(9, 1, 0, 0, 1, 0, 21, 0, 7);
      cyc();
      check("t2_count1", iq_count, 1);
      check("t2_unready", issue_valid, 0);
      enq(33, 1, 1, 0, 0, 0, 22, 0, 8);
      expect_issue(0, 8);
      cyc();
      check("t2_count2", iq_count, 2);
      check("t2_first_robidx", issue_robidx, 8);
      cyc();
      check("t2_still_waiting", issue_valid, 0);
      wb0_valid = 1'b1; wb0_prd = 9;
      expect_issue(0, 7);
      cyc();
      check("t2_woken", issue_valid, 1);
      check("t2_woken_robidx", issue_robidx, 7);
      cyc();
      check("t2_count0", iq_count, 0);

      // ROB wrap: flag0/idx14 is older than flag1/idx1
      issue_ready = 1'b0;
      enq(1, 1, 1, 2, 1, 1, 23, 0, 14);
      cyc();
      enq(3, 1, 1, 4, 1, 1, 24, 1, 1);
      cyc();
      check("t3_count2", iq_count, 2);
      check("t3_oldest", {issue_robidx_flag, issue_robidx}, {1'b0, 4'd14});
      expect_issue(0, 14);
      expect_issue(1, 1);
      issue_ready = 1'b1;
      cyc();
      check("t3_second", {issue_robidx_flag, issue_robidx}, {1'b1, 4'd1});
      cyc();
      check("t3_count0", iq_count, 0);

      // fill with unready entries; full blocks enqueue; one issue reopens
      for (int i = 0; i < 8; i++) begin
         enq(6'(10 + i), 1, 0, 0, 1, 0, 6'(40 + i), 0, 4'(i));
         cyc();
      end
      check("t4_full_count", iq_count, 8);
      check("t4_full_enq_ready", enq_ready, 0);
      check("t4_full_no_issue", issue_valid, 0);
      enq(50, 1, 1, 0, 1, 0, 60, 0, 9);
      cyc();
      check("t4_enq_ignored_count", iq_count, 8);
      check("t4_enq_ignored_issue", issue_valid, 0);
      wb0_valid = 1'b1; wb0_prd = 13;
      expect_issue(0, 3);
      cyc();
      check("t4_woken_robidx", {issue_valid, issue_robidx}, {1'b1, 4'd3});
      check("t4_still_full", enq_ready, 0);
      cyc();
      check("t4_reopen", enq_ready, 1);
      check("t4_count7", iq_count, 7);
      // mid-operation reset drops everything immediately
      reset = 1'b1;
      #1;
      check("t4_rst_count", iq_count, 0);
      check("t4_rst_issue", issue_valid, 0);
      check("t4_rst_enq_ready", enq_ready, 1);
      reset = 1'b0;
      #1;

      // selective flush keeps 2 and 4, kills 6; wakeup during flush lands
      enq(30, 1, 0, 0, 1, 0, 26, 0, 2); cyc();
      enq(31, 1, 0, 0, 1, 0, 27, 0, 4); cyc();
      enq(32, 1, 0, 0, 1, 0, 28, 0, 6); cyc();
      check("t5_count3", iq_count, 3);
      wb0_valid = 1'b1; wb0_prd = 30;
      cyc();
      enq(50, 1, 1, 0, 1, 0, 61, 0, 1);
      flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = 4;
      wb0_valid = 1'b1; wb0_prd = 31;
      #1;
      check("t5_flush_blocks_issue", issue_valid, 0);
      cyc();
      check("t5_count2", iq_count, 2);
      expect_issue(0, 2);
      expect_issue(0, 4);
      check("t5_survivor", {issue_valid, issue_robidx}, {1'b1, 4'd2});
      cyc();
      check("t5_flush_idx_kept", {issue_valid, issue_robidx}, {1'b1, 4'd4});
      cyc();
      check("t5_count0", iq_count, 0);
      wb0_valid = 1'b1; wb0_prd = 32;
      cyc();
      check("t5_killed_stays_dead", issue_valid, 0);
      check("t5_killed_count", iq_count, 0);

      // enqueue bypass on src2 (src1 not a register)
      enq(40, 0, 0, 12, 1, 0, 29, 0, 5);
      wb0_valid = 1'b1; wb0_prd = 12;
      expect_issue(0, 5);
      cyc();
      check("t6_bypass", {issue_valid, issue_robidx}, {1'b1, 4'd5});
      cyc();
      check("t6_count0", iq_count, 0);

      // non-matching wakeup does not bypass; the matching one later does
      enq(13, 1, 0, 0, 1, 0, 30, 0, 6);
      wb0_valid = 1'b1; wb0_prd = 14;
      cyc();
      check("t7_no_false_wake", issue_valid, 0);
      wb0_valid = 1'b1; wb0_prd = 13;
      expect_issue(0, 6);
      cyc();
      check("t7_wake", {issue_valid, issue_robidx}, {1'b1, 4'd6});
      cyc();
      check("t7_count0", iq_count, 0);

`ifdef IQ_DUAL_WAKEUP_EN
      // second wakeup port: bypass and resident wakeup
      enq(12, 1, 0, 0, 1, 0, 31, 0, 7);
      wb1_valid = 1'b1; wb1_prd = 12;
      expect_issue(0, 7);
      cyc();
      check("t8_wb1_bypass", {issue_valid, issue_robidx}, {1'b1, 4'd7});
      cyc();
      enq(15, 1, 0, 0, 1, 0, 32, 0, 8);
      cyc();
      check("t8_unready", issue_valid, 0);
      wb1_valid = 1'b1; wb1_prd = 15;
      expect_issue(0, 8);
      cyc();
      check("t8_wb1_wake", {issue_valid, issue_robidx}, {1'b1, 4'd8});
      cyc();
      check("t8_count0", iq_count, 0);
`endif

      check("sb_drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
